nec_ir_rx: RTL and testbench

//  Receive-side NEC IR decoder; the counterpart of the proc-driven IR transmit path.

---
 rtl/nec_ir_rx.sv | 197 +++++++++++++++++++
 tb/tb_nec_ir_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nec_ir_rx.sv
// NEC IR receive decoder: synchroniser, glitch filter, segment timer and
// frame FSM producing address/command plus valid/repeat/error strobes.
module nec_ir_rx #(
    parameter int UNIT_CYCLES   = 5625,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ir_n,
    output logic       o_valid,
    output logic       o_repeat,
    output logic       o_error,
    output logic [7:0] o_addr,
    output logic [7:0] o_cmd,
    output logic       o_busy
);
    localparam int DW = $clog2(UNIT_CYCLES * 20 + 1);
    localparam int SW = DW + 1;
    localparam int GW = $clog2(GLITCH_CYCLES + 1);

    localparam logic [SW-1:0] LO1  = SW'(UNIT_CYCLES * 3 / 4);
    localparam logic [SW-1:0] HI1  = SW'(UNIT_CYCLES * 5 / 4);
    localparam logic [SW-1:0] LO3  = SW'(3 * UNIT_CYCLES * 3 / 4);
    localparam logic [SW-1:0] HI3  = SW'(3 * UNIT_CYCLES * 5 / 4);
    localparam logic [SW-1:0] LO4  = SW'(4 * UNIT_CYCLES * 3 / 4);
    localparam logic [SW-1:0] HI4  = SW'(4 * UNIT_CYCLES * 5 / 4);
    localparam logic [SW-1:0] LO8  = SW'(8 * UNIT_CYCLES * 3 / 4);
    localparam logic [SW-1:0] HI8  = SW'(8 * UNIT_CYCLES * 5 / 4);
    localparam logic [SW-1:0] LO16 = SW'(16 * UNIT_CYCLES * 3 / 4);
    localparam logic [SW-1:0] HI16 = SW'(16 * UNIT_CYCLES * 5 / 4);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LEAD_MARK  = 3'd1;
    localparam logic [2:0] S_LEAD_SPACE = 3'd2;
    localparam logic [2:0] S_BIT_MARK   = 3'd3;
    localparam logic [2:0] S_BIT_SPACE  = 3'd4;
    localparam logic [2:0] S_STOP_MARK  = 3'd5;
    localparam logic [2:0] S_REP_STOP   = 3'd6;

    logic          sync1, sync2, filt, filt_q;
    logic [GW-1:0] gcnt;
    logic [DW-1:0] dur;
    logic [SW-1:0] seg, tmax;
    logic [2:0]    state, nxt;
    logic [31:0]   sr;
    logic [4:0]    bit_cnt;
    logic          got_frame;
    logic          edge_seen, err, shift, bitv, fin, rep, chk_ok;

    function automatic logic win(input logic [SW-1:0] d,
                                 input logic [SW-1:0] lo,
                                 input logic [SW-1:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            filt   <= 1'b1;
            filt_q <= 1'b1;
            gcnt   <= '0;
        end else begin
            sync1  <= i_ir_n;
            sync2  <= sync1;
            filt_q <= filt;
            if (sync2 == filt) begin
                gcnt <= '0;
            end else if (gcnt == GW'(GLITCH_CYCLES - 1)) begin
                filt <= sync2;
                gcnt <= '0;
            end else begin
                gcnt <= gcnt + GW'(1);
            end
        end
    end

    // dur counts cycles after the edge cycle, so the segment length is dur+1
    assign edge_seen = filt ^ filt_q;
    assign seg       = {1'b0, dur} + SW'(1);
    assign chk_ok    = ((sr[7:0] ^ sr[15:8]) == 8'hFF)
                    && ((sr[23:16] ^ sr[31:24]) == 8'hFF);
    assign o_busy    = (state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            dur <= '0;
        end else if (edge_seen) begin
            dur <= '0;
        end else if (dur != '1) begin
            dur <= dur + DW'(1);
        end
    end

    always_comb begin
        tmax = '1;
        unique case (state)
            S_LEAD_MARK:  tmax = HI16;
            S_LEAD_SPACE: tmax = HI8;
            S_BIT_SPACE:  tmax = HI3;
            S_BIT_MARK,
            S_STOP_MARK,
            S_REP_STOP:   tmax = HI1;
            default:      tmax = '1;
        endcase
    end

    always_comb begin
        nxt   = state;
        err   = 1'b0;
        shift = 1'b0;
        bitv  = 1'b0;
        fin   = 1'b0;
        rep   = 1'b0;
        if (state != S_IDLE && !edge_seen && seg > tmax) begin
            err = 1'b1;
        end else if (edge_seen) begin
            unique case (state)
                S_IDLE: begin
                    if (!filt) nxt = S_LEAD_MARK;
                end
                S_LEAD_MARK: begin
                    nxt = win(seg, LO16, HI16) ? S_LEAD_SPACE : S_IDLE;
                end
                S_LEAD_SPACE: begin
                    if (win(seg, LO8, HI8))      nxt = S_BIT_MARK;
                    else if (win(seg, LO4, HI4)) nxt = S_REP_STOP;
                    else                         err = 1'b1;
                end
                S_BIT_MARK: begin
                    if (win(seg, LO1, HI1)) nxt = S_BIT_SPACE;
                    else                    err = 1'b1;
                end
                S_BIT_SPACE: begin
                    if (win(seg, LO1, HI1) || win(seg, LO3, HI3)) begin
                        shift = 1'b1;
                        bitv  = win(seg, LO3, HI3);
                        nxt   = (bit_cnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                    end else begin
                        err = 1'b1;
                    end
                end
                S_STOP_MARK: begin
                    if (win(seg, LO1, HI1)) fin = 1'b1;
                    else                    err = 1'b1;
                end
                S_REP_STOP: begin
                    if (win(seg, LO1, HI1)) rep = 1'b1;
                    else                    err = 1'b1;
                end
                default: err = 1'b1;
            endcase
        end
        if (err || fin || rep) nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= S_IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            got_frame <= 1'b0;
            o_valid   <= 1'b0;
            o_repeat  <= 1'b0;
            o_error   <= 1'b0;
            o_addr    <= '0;
            o_cmd     <= '0;
        end else begin
            state    <= nxt;
            o_valid  <= 1'b0;
            o_repeat <= 1'b0;
            o_error  <= err;
            if (shift) begin
                sr[bit_cnt] <= bitv;
                bit_cnt     <= bit_cnt + 5'd1;
            end
            if (fin) begin
                if (chk_ok) begin
                    o_addr    <= sr[7:0];
                    o_cmd     <= sr[23:16];
                    o_valid   <= 1'b1;
                    got_frame <= 1'b1;
                end else begin
                    o_error <= 1'b1;
                end
            end
            if (rep) begin
                o_repeat <= got_frame;
                o_error  <= !got_frame;
            end
            if (nxt == S_IDLE) begin
                sr      <= '0;
                bit_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_nec_ir_rx.sv
// Randomised scoreboard bench for nec_ir_rx: a frame-level model predicts
// each strobe, and a monitor compares every strobe the decoder emits.
module tb_nec_ir_rx;
    localparam int U = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ir_n = 1'b1;
    logic       o_valid, o_repeat, o_error, o_busy;
    logic [7:0] o_addr, o_cmd;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] addr;
        logic [7:0] cmd;
    } ev_t;

    ev_t        q[$];
    int         compared = 0;
    int         mismatched = 0;
    bit         got = 0;
    logic [7:0] la = 8'h00;
    logic [7:0] lc = 8'h00;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_REP   = 3'b010;
    localparam logic [2:0] K_ERR   = 3'b001;

    nec_ir_rx #(.UNIT_CYCLES(U), .GLITCH_CYCLES(2)) dut (
        .i_clk    (clk),
        .i_rst    (rst_n),
        .i_ir_n   (ir_n),
        .o_valid  (o_valid),
        .o_repeat (o_repeat),
        .o_error  (o_error),
        .o_addr   (o_addr),
        .o_cmd    (o_cmd),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (o_valid || o_repeat || o_error) begin
            check("strobe_onehot",
                  32'($countones({o_valid, o_repeat, o_error})), 1);
            if (q.size() == 0) begin
                check("unexpected_strobe",
                      {29'd0, o_valid, o_repeat, o_error}, 0);
            end else begin
                e = q.pop_front();
                check("strobe_kind", {29'd0, o_valid, o_repeat, o_error},
                      {29'd0, e.kind});
                check("addr", {24'd0, o_addr}, {24'd0, e.addr});
                check("cmd", {24'd0, o_cmd}, {24'd0, e.cmd});
            end
        end
    end

    function automatic void push_frame(input logic [7:0] b0, b1, b2, b3);
        ev_t e;
        if ((b0 ^ b1) == 8'hFF && (b2 ^ b3) == 8'hFF) begin
            got = 1;
            la  = b0;
            lc  = b2;
            e.kind = K_VALID;
        end else begin
            e.kind = K_ERR;
        end
        e.addr = la;
        e.cmd  = lc;
        q.push_back(e);
    endfunction

    function automatic void push_repeat();
        ev_t e;
        e.kind = got ? K_REP : K_ERR;
        e.addr = la;
        e.cmd  = lc;
        q.push_back(e);
    endfunction

    function automatic int jt(input bit en);
        return en ? int'($urandom_range(0, 2)) - 1 : 0;
    endfunction

    task automatic level(input logic v, input int cycles);
        ir_n = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [31:0] w, input int stop_at,
                              input int glitch_bit, input bit jit);
        int sp;
        level(0, 16 * U + jt(jit));
        level(1, 8 * U + jt(jit));
        for (int i = 0; i < 32; i++) begin
            if (i == stop_at) begin
                level(0, U / 2);
                return;
            end
            level(0, U + jt(jit));
            sp = (w[i] ? 3 : 1) * U;
            if (i == glitch_bit) begin
                level(1, 3);
                level(0, 1);
                level(1, sp - 4);
            end else begin
                level(1, sp + jt(jit));
            end
        end
        level(0, U + jt(jit));
        level(1, 30 * U);
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3,
                              input int glitch_bit, input bit jit);
        push_frame(b0, b1, b2, b3);
        send_bytes({b3, b2, b1, b0}, 99, glitch_bit, jit);
    endtask

    task automatic send_repeat();
        push_repeat();
        level(0, 16 * U);
        level(1, 4 * U);
        level(0, U);
        level(1, 30 * U);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ir_n  = 1'b1;
        #1;
        check("rst_outputs",
              {8'd0, o_valid, o_repeat, o_error, o_busy, 4'd0, o_addr, o_cmd},
              0);
        got = 0;
        la  = 8'h00;
        lc  = 8'h00;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d",
                 compared);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, c, b1, b3;
        int r;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state",
              {8'd0, o_valid, o_repeat, o_error, o_busy, 4'd0, o_addr, o_cmd},
              0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        send_frame(8'h04, 8'hFB, 8'h08, 8'hF7, 99, 0);
        send_repeat();
        send_frame(8'h04, 8'hFB, 8'h08, 8'hF6, 99, 0);
        send_frame(8'h04, 8'hFB, 8'h10, 8'hEF, 99, 0);

        pulse_reset();
        send_repeat();
        level(0, 10 * U);
        level(1, 30 * U);
        check("busy_after_short_leader", {31'd0, o_busy}, 0);

        level(0, 2);
        level(1, 20);
        check("busy_after_idle_glitch", {31'd0, o_busy}, 0);
        send_frame(8'h21, 8'hDE, 8'h43, 8'hBC, 5, 0);

        send_bytes({8'hC3, 8'h3C, 8'h5A, 8'hA5}, 10, 99, 0);
        rst_n = 1'b0;
        #1;
        check("mid_frame_reset",
              {8'd0, o_valid, o_repeat, o_error, o_busy, 4'd0, o_addr, o_cmd},
              0);
        got = 0;
        la  = 8'h00;
        lc  = 8'h00;
        ir_n = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'hA5, 8'h5A, 8'h3C, 8'hC3, 99, 0);

        begin
            ev_t e;
            e.kind = K_ERR;
            e.addr = la;
            e.cmd  = lc;
            q.push_back(e);
        end
        level(0, 16 * U);
        level(1, 8 * U);
        level(0, U);
        level(1, U);
        level(0, 25 * U);
        level(1, 30 * U);

        for (int n = 0; n < 20; n++) begin
            r  = $urandom_range(0, 3);
            a  = 8'($urandom);
            c  = 8'($urandom);
            b1 = ~a;
            b3 = ~c;
            if (r == 2) begin
                if ($urandom_range(0, 1) == 1)
                    b1 = b1 ^ (8'h01 << $urandom_range(0, 7));
                else
                    b3 = b3 ^ (8'h01 << $urandom_range(0, 7));
            end
            if (r == 3) send_repeat();
            else send_frame(a, b1, c, b3, 99, 1);
        end

        repeat (50) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
